link_frame_aligner: RTL and testbench

Per-link frame aligner that sits directly downstream of the I/O block's receive byte stream, in the `clk160` domain. It consumes the 8-bit deserialized bytes, searches all 8 bit offsets for a fixed sync word, and confirms that the sync word repeats at a fixed frame period. Once locked, it emits aligned 32-bit words with a start-of-frame flag and keeps alignment-health counters for the register interface.

---
 rtl/link_frame_aligner.sv | 177 +++++++++++++++++
 tb/tb_link_frame_aligner.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_frame_aligner.sv
// link_frame_aligner: 8-offset sync search, frame lock and
// aligned 32-bit word output for one receive link.
module link_frame_aligner #(
  parameter logic [31:0] SYNC_WORD    = 32'h9CCC_CCCC,
  parameter int          FRAME_WORDS  = 8,
  parameter int          LOCK_COUNT   = 4,
  parameter int          UNLOCK_COUNT = 3
) (
  input  logic        clk160,
  input  logic        reset,
  input  logic [7:0]  in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  output logic        out_tsof,
  input  logic        clear_counters,
  output logic        locked,
  output logic [2:0]  bit_offset,
  output logic [15:0] sync_errors,
  output logic [7:0]  lock_losses
);

  localparam int IW = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_WORDS - 1);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH,
    CONFIRM,
    LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   hist;
  logic [39:0]   win;
  logic [31:0]   cur_word;
  logic [1:0]    byte_cnt, byte_cnt_d;
  logic [IW-1:0] word_idx, word_idx_d;
  logic [3:0]    good_cnt, good_cnt_d;
  logic [3:0]    miss_cnt, miss_cnt_d;
  logic [2:0]    offset_d, hit_off;
  logic          hit;
  logic          word_done, slot0, is_sync;
  logic          emit, emit_sof, err_inc, loss_inc;

  assign in_tready = 1'b1;
  assign locked    = (state_q == LOCKED);
  assign win       = {hist, in_tdata};
  assign cur_word  = win[{3'b000, bit_offset} +: 32];
  assign slot0     = (word_idx == '0);
  assign is_sync   = (cur_word == SYNC_WORD);
  assign word_done = in_tvalid && (state_q != SEARCH)
                     && (byte_cnt == 2'd3);

  // sync search over all offsets; the lowest matching offset wins
  always_comb begin
    hit     = 1'b0;
    hit_off = 3'd0;
    for (int b = 7; b >= 0; b--) begin
      if (win[6'(b) +: 32] == SYNC_WORD) begin
        hit     = 1'b1;
        hit_off = 3'(b);
      end
    end
  end

  // next state, word/slot tracking and output/counter decode
  always_comb begin
    state_d    = state_q;
    offset_d   = bit_offset;
    byte_cnt_d = byte_cnt;
    word_idx_d = word_idx;
    good_cnt_d = good_cnt;
    miss_cnt_d = miss_cnt;
    emit       = 1'b0;
    emit_sof   = 1'b0;
    err_inc    = 1'b0;
    loss_inc   = 1'b0;
    if (in_tvalid) begin
      unique case (state_q)
        SEARCH: begin
          if (hit) begin
            state_d    = CONFIRM;
            offset_d   = hit_off;
            byte_cnt_d = 2'd0;
            word_idx_d = IW'(1);
            good_cnt_d = 4'd1;
          end
        end
        CONFIRM, LOCKED: begin
          byte_cnt_d = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            word_idx_d = (word_idx == LAST_IDX) ? '0
                         : word_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
    if (word_done && slot0 && state_q == CONFIRM) begin
      if (!is_sync) begin
        state_d = SEARCH;
      end else begin
        good_cnt_d = good_cnt + 4'd1;
        if (good_cnt + 4'd1 == LOCK_N) begin
          state_d    = LOCKED;
          miss_cnt_d = 4'd0;
          emit       = 1'b1;
          emit_sof   = 1'b1;
        end
      end
    end
    if (word_done && state_q == LOCKED) begin
      emit     = 1'b1;
      emit_sof = slot0;
      if (slot0) begin
        if (is_sync) begin
          miss_cnt_d = 4'd0;
        end else begin
          err_inc    = 1'b1;
          miss_cnt_d = miss_cnt + 4'd1;
          if (miss_cnt + 4'd1 == UNLOCK_N) begin
            state_d  = SEARCH;
            loss_inc = 1'b1;
          end
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk160) begin
    if (reset) state_q <= SEARCH;
    else       state_q <= state_d;
  end

  // byte history, alignment registers and registered word output
  always_ff @(posedge clk160) begin
    if (reset) begin
      hist       <= '0;
      bit_offset <= '0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tsof   <= 1'b0;
    end else begin
      if (in_tvalid) hist <= {hist[23:0], in_tdata};
      bit_offset <= offset_d;
      byte_cnt   <= byte_cnt_d;
      word_idx   <= word_idx_d;
      good_cnt   <= good_cnt_d;
      miss_cnt   <= miss_cnt_d;
      out_tvalid <= emit;
      out_tsof   <= emit_sof;
      if (emit) out_tdata <= cur_word;
    end
  end

  // saturating health counters; a clear beats an increment
  always_ff @(posedge clk160) begin
    if (reset || clear_counters) begin
      sync_errors <= '0;
      lock_losses <= '0;
    end else begin
      if (err_inc && sync_errors != 16'hFFFF)
        sync_errors <= sync_errors + 16'd1;
      if (loss_inc && lock_losses != 8'hFF)
        lock_losses <= lock_losses + 8'd1;
    end
  end

endmodule

// File: tb/tb_link_frame_aligner.sv
// tb_link_frame_aligner: bit-stream reference model and
// scenario tasks for link_frame_aligner.
module tb_link_frame_aligner;

  localparam logic [31:0] SYNC = 32'h9CCC_CCCC;
  localparam logic [31:0] BAD  = 32'h9CCC_CCCD;
  localparam int FW = 8;
  localparam int LK = 4;
  localparam int UL = 3;
  localparam int SRCH = 0;
  localparam int CONF = 1;
  localparam int LOCK = 2;

  logic        clk160 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_tdata = '0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tsof;
  logic        clear_counters = 1'b0;
  logic        locked;
  logic [2:0]  bit_offset;
  logic [15:0] sync_errors;
  logic [7:0]  lock_losses;

  always #5 clk160 = ~clk160;

  link_frame_aligner #(
    .SYNC_WORD(SYNC), .FRAME_WORDS(FW),
    .LOCK_COUNT(LK), .UNLOCK_COUNT(UL)
  ) dut (
    .clk160(clk160), .reset(reset),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tsof(out_tsof),
    .clear_counters(clear_counters),
    .locked(locked), .bit_offset(bit_offset),
    .sync_errors(sync_errors), .lock_losses(lock_losses)
  );

  int passed = 0;
  int total = 0;

  // reference model: every received bit since reset,
  // preceded by 32 zero bits standing in for the cleared history
  bit          mbits[$];
  int          mst, moff, mend, mword, mgood, mmiss, merr, mloss;
  logic        e_tv, e_sof;
  logic [31:0] e_data;

  bit          sbits[$];
  logic [7:0]  stream[$];
  logic [31:0] clean_q[$];
  logic [31:0] got_q[$];

  function automatic logic [31:0] word_at(int e);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[31-i] = mbits[e-31+i];
    return w;
  endfunction

  task automatic model_reset();
    mbits = {};
    repeat (32) mbits.push_back(1'b0);
    mst = SRCH; moff = 0; mend = 0; mword = 0;
    mgood = 0; mmiss = 0; merr = 0; mloss = 0;
    e_tv = 1'b0; e_sof = 1'b0; e_data = '0;
  endtask

  task automatic model_byte(input logic [7:0] d);
    int last, slot;
    bit found;
    logic [31:0] w;
    e_tv = 1'b0;
    e_sof = 1'b0;
    for (int i = 7; i >= 0; i--) mbits.push_back(d[i]);
    last = mbits.size() - 1;
    if (mst == SRCH) begin
      found = 0;
      for (int b = 0; b < 8; b++) begin
        if (!found && word_at(last - b) == SYNC) begin
          found = 1; mst = CONF; moff = b;
          mend = last - b + 32; mword = 0; mgood = 1;
        end
      end
    end else if (mend <= last) begin
      w = word_at(mend);
      mend += 32;
      mword++;
      slot = mword % FW;
      if (mst == CONF) begin
        if (slot == 0) begin
          if (w != SYNC) mst = SRCH;
          else begin
            mgood++;
            if (mgood == LK) begin
              mst = LOCK; mmiss = 0;
              e_tv = 1'b1; e_sof = 1'b1; e_data = w;
            end
          end
        end
      end else begin
        e_tv = 1'b1; e_sof = (slot == 0); e_data = w;
        if (slot == 0) begin
          if (w == SYNC) mmiss = 0;
          else begin
            if (merr < 65535) merr++;
            mmiss++;
            if (mmiss == UL) begin
              mst = SRCH;
              if (mloss < 255) mloss++;
            end
          end
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d,
                      input logic clr, input logic rst);
    in_tvalid = v;
    in_tdata = d;
    clear_counters = clr;
    reset = rst;
    @(posedge clk160);
    #1;
    if (rst) model_reset();
    else begin
      if (v) model_byte(d);
      else begin
        e_tv = 1'b0;
        e_sof = 1'b0;
      end
      if (clr) begin
        merr = 0;
        mloss = 0;
      end
    end
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  function automatic logic [61:0] act_vec();
    return {out_tvalid, out_tvalid ? out_tdata : 32'h0,
            out_tvalid & out_tsof, locked, bit_offset,
            sync_errors, lock_losses};
  endfunction

  function automatic logic [61:0] exp_vec();
    return {e_tv, e_tv ? e_data : 32'h0, e_tv & e_sof,
            mst == LOCK, 3'(moff), 16'(merr), 8'(mloss)};
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) sbits.push_back(w[i]);
  endtask

  task automatic pack();
    logic [7:0] b;
    while (sbits.size() % 8 != 0) sbits.push_back(1'b0);
    stream = {};
    for (int i = 0; i < sbits.size(); i += 8) begin
      for (int j = 0; j < 8; j++) b[7-j] = sbits[i+j];
      stream.push_back(b);
    end
  endtask

  // zero prefix of 32-shift bits lands the sync at offset=shift
  task automatic build(input int shift, input int nfr,
                       input logic [31:0] bad);
    int cnt;
    cnt = 1;
    sbits = {};
    repeat (32 - shift) sbits.push_back(1'b0);
    for (int f = 0; f < nfr; f++) begin
      push_word(bad[f] ? BAD : SYNC);
      for (int k = 1; k < FW; k++) begin
        push_word(32'(cnt));
        cnt++;
      end
    end
    pack();
  endtask

  function automatic int sync_byte(int shift, int f);
    return (32 - shift + 256 * f + 31) / 8;
  endfunction

  task automatic test_reset();
    do_reset();
    total++;
    if ({out_tdata, out_tvalid, out_tsof, locked, bit_offset,
         sync_errors, lock_losses} !== '0) begin
      $display("FAIL reset_outputs: got %h %b %b %b %0d %0d %0d want all 0",
               out_tdata, out_tvalid, out_tsof, locked,
               bit_offset, sync_errors, lock_losses);
    end else passed++;
    total++;
    if (in_tready !== 1'b1)
      $display("FAIL in_tready: got %b want 1", in_tready);
    else passed++;
  endtask

  task automatic test_clean_lock();
    int lock_at, gaps;
    build(3, 6, 32'h0);
    do_reset();
    lock_at = -1;
    clean_q = {};
    for (int i = 0; i < stream.size(); i++) begin
      step(1'b1, stream[i], 1'b0, 1'b0);
      total++;
      if (act_vec() !== exp_vec())
        $display("FAIL clean byte %0d: got %h want %h",
                 i, act_vec(), exp_vec());
      else passed++;
      if (locked && lock_at < 0) begin
        lock_at = i;
        total++;
        if (!(out_tvalid && out_tsof && out_tdata == SYNC)
            || i != sync_byte(3, 3))
          $display("FAIL clean_lock_point: got byte %0d tv %b sof %b data %h want byte %0d 1 1 %h",
                   i, out_tvalid, out_tsof, out_tdata,
                   sync_byte(3, 3), SYNC);
        else passed++;
      end
      if (out_tvalid && !out_tsof) clean_q.push_back(out_tdata);
    end
    total++;
    if (bit_offset !== 3'd3 || locked !== 1'b1)
      $display("FAIL clean_offset: got %0d locked %b want 3 1",
               bit_offset, locked);
    else passed++;
    gaps = 0;
    for (int k = 1; k < clean_q.size(); k++)
      if (clean_q[k] != clean_q[k-1] + 1) gaps++;
    total++;
    if (clean_q.size() != 21 || clean_q[0] != 32'd22 || gaps != 0)
      $display("FAIL clean_sequence: got n %0d first %0d gaps %0d want 21 22 0",
               clean_q.size(), clean_q.size() ? clean_q[0] : 0, gaps);
    else passed++;
  endtask

  task automatic test_all_offsets();
    for (int s = 0; s < 8; s++) begin
      build(s, 5, 32'h0);
      do_reset();
      for (int i = 0; i < stream.size(); i++) begin
        step(1'b1, stream[i], 1'b0, 1'b0);
        total++;
        if (act_vec() !== exp_vec())
          $display("FAIL offset%0d byte %0d: got %h want %h",
                   s, i, act_vec(), exp_vec());
        else passed++;
      end
      total++;
      if (bit_offset !== 3'(s) || locked !== 1'b1)
        $display("FAIL offset%0d_lock: got %0d locked %b want %0d 1",
                 s, bit_offset, locked, s);
      else passed++;
    end
  endtask

  task automatic test_false_hit();
    bit any_tv;
    sbits = {};
    repeat (27) sbits.push_back(1'b0);
    push_word(SYNC);
    for (int k = 1; k <= 12; k++) push_word(32'(k));
    pack();
    do_reset();
    any_tv = 0;
    for (int i = 0; i < stream.size(); i++) begin
      step(1'b1, stream[i], 1'b0, 1'b0);
      if (out_tvalid) any_tv = 1;
      total++;
      if (act_vec() !== exp_vec())
        $display("FAIL false_hit byte %0d: got %h want %h",
                 i, act_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (any_tv || locked || lock_losses != 8'd0
        || bit_offset != 3'd5)
      $display("FAIL false_hit_end: got tv %b locked %b losses %0d off %0d want 0 0 0 5",
               any_tv, locked, lock_losses, bit_offset);
    else passed++;
  endtask

  task automatic test_errors_locked();
    build(3, 13, 32'h0000_0EA0);
    do_reset();
    for (int i = 0; i < stream.size(); i++) begin
      step(1'b1, stream[i], 1'b0, 1'b0);
      total++;
      if (act_vec() !== exp_vec())
        $display("FAIL errors byte %0d: got %h want %h",
                 i, act_vec(), exp_vec());
      else passed++;
      if (i == sync_byte(3, 8)) begin
        total++;
        if (sync_errors !== 16'd2 || locked !== 1'b1)
          $display("FAIL errors_two: got %0d locked %b want 2 1",
                   sync_errors, locked);
        else passed++;
      end
      if (i == sync_byte(3, 11)) begin
        total++;
        if (sync_errors !== 16'd5 || lock_losses !== 8'd1
            || locked !== 1'b0 || !out_tvalid || !out_tsof
            || out_tdata !== BAD)
          $display("FAIL errors_unlock: got err %0d loss %0d locked %b tv %b sof %b data %h want 5 1 0 1 1 %h",
                   sync_errors, lock_losses, locked, out_tvalid,
                   out_tsof, out_tdata, BAD);
        else passed++;
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (sync_errors !== 16'd0 || lock_losses !== 8'd0)
      $display("FAIL clear_only: got %0d %0d want 0 0",
               sync_errors, lock_losses);
    else passed++;
  endtask

  task automatic test_gapped();
    int i, cyc;
    logic v;
    bit diff;
    build(3, 6, 32'h0);
    do_reset();
    got_q = {};
    i = 0;
    cyc = 0;
    while (i < stream.size() && cyc < 5000) begin
      v = 1'($urandom_range(0, 1));
      step(v, v ? stream[i] : 8'($urandom), 1'b0, 1'b0);
      if (v) i++;
      cyc++;
      total++;
      if (act_vec() !== exp_vec())
        $display("FAIL gapped cycle %0d: got %h want %h",
                 cyc, act_vec(), exp_vec());
      else passed++;
      if (out_tvalid && !out_tsof) got_q.push_back(out_tdata);
    end
    diff = (i != stream.size()) || (got_q.size() != clean_q.size());
    if (!diff)
      foreach (got_q[k]) if (got_q[k] != clean_q[k]) diff = 1;
    total++;
    if (diff || bit_offset !== 3'd3 || locked !== 1'b1)
      $display("FAIL gapped_sequence: got n %0d off %0d locked %b want n %0d 3 1",
               got_q.size(), bit_offset, locked, clean_q.size());
    else passed++;
  endtask

  task automatic test_reset_relock();
    int stop;
    build(6, 10, 32'h0);
    do_reset();
    stop = sync_byte(6, 4) + 10;
    for (int i = 0; i < stream.size(); i++) begin
      step(1'b1, stream[i], 1'b0, 1'b0);
      total++;
      if (act_vec() !== exp_vec())
        $display("FAIL relock byte %0d: got %h want %h",
                 i, act_vec(), exp_vec());
      else passed++;
      if (i == stop) begin
        total++;
        if (locked !== 1'b1)
          $display("FAIL relock_pre: got %b want 1", locked);
        else passed++;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if ({out_tdata, out_tvalid, out_tsof, locked, bit_offset,
             sync_errors, lock_losses} !== '0)
          $display("FAIL relock_reset: got %h %b %b %b %0d want all 0",
                   out_tdata, out_tvalid, out_tsof, locked, bit_offset);
        else passed++;
      end
      if (i == sync_byte(6, 7)) begin
        total++;
        if (locked !== 1'b0)
          $display("FAIL relock_third: got %b want 0", locked);
        else passed++;
      end
      if (i == sync_byte(6, 8)) begin
        total++;
        if (locked !== 1'b1 || !out_tvalid || !out_tsof)
          $display("FAIL relock_fourth: got %b %b %b want 1 1 1",
                   locked, out_tvalid, out_tsof);
        else passed++;
      end
    end
  endtask

  task automatic test_clear_coincident();
    logic clr;
    build(2, 8, 32'h0000_0060);
    do_reset();
    for (int i = 0; i < stream.size(); i++) begin
      clr = (i == sync_byte(2, 6));
      step(1'b1, stream[i], clr, 1'b0);
      total++;
      if (act_vec() !== exp_vec())
        $display("FAIL clear byte %0d: got %h want %h",
                 i, act_vec(), exp_vec());
      else passed++;
      if (i == sync_byte(2, 5)) begin
        total++;
        if (sync_errors !== 16'd1)
          $display("FAIL clear_pre: got %0d want 1", sync_errors);
        else passed++;
      end
      if (clr) begin
        total++;
        if (sync_errors !== 16'd0 || locked !== 1'b1)
          $display("FAIL clear_vs_error: got %0d locked %b want 0 1",
                   sync_errors, locked);
        else passed++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_lock();
    test_all_offsets();
    test_false_hit();
    test_errors_locked();
    test_gapped();
    test_reset_relock();
    test_clear_coincident();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
